gpu_text_ctrl: RTL and testbench

Command sequencer and text-RAM arbiter for the GPU text mode. It accepts opcode/parameter pairs from the CPU through a valid/ready handshake and buffers them in a 4-entry FIFO. It executes the character-cell commands (put, backspace, cursor moves, newline, clear) against a single-port 40x25 character RAM. That RAM is shared with the display fetch path, which always has priority.

---
 rtl/gpu_text_ctrl.sv | 170 +++++++++++++++++
 tb/tb_gpu_text_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_text_ctrl.sv
// gpu_text_ctrl: command FIFO plus cell-command sequencer sharing a single-port
// character RAM with the display fetch path, which always wins arbitration.
module gpu_text_ctrl #(
    parameter int COLS       = 40,
    parameter int ROWS       = 25,
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [7:0]        i_cmd_op,
    input  logic [15:0]       i_cmd_param,
    input  logic              i_disp_req,
    input  logic [ADDR_W-1:0] i_disp_addr,
    output logic              o_disp_ack,
    output logic [7:0]        o_disp_data,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    input  logic [7:0]        i_mem_rdata,
    output logic [5:0]        o_cur_x,
    output logic [4:0]        o_cur_y,
    output logic              o_busy,
    output logic              o_cmd_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [7:0] OP_HOME = 8'hC0;
    localparam logic [7:0] OP_PUT  = 8'hC1;
    localparam logic [7:0] OP_BS   = 8'hC2;
    localparam logic [7:0] OP_ROW  = 8'hC3;
    localparam logic [7:0] OP_COL  = 8'hC4;
    localparam logic [7:0] OP_CLR  = 8'hC5;
    localparam logic [7:0] OP_NL   = 8'hC6;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR} state_t;

    state_t            r_state, w_state_nx;
    logic [23:0]       r_fifo [FIFO_DEPTH];
    logic [PW-1:0]     r_wp, r_rp;
    logic [PW:0]       r_cnt, w_cnt_nx;
    logic              r_full, w_push, w_pop;
    logic [7:0]        r_op;
    logic [15:0]       r_param;
    logic [5:0]        r_x, w_bs_x;
    logic [4:0]        r_y, w_bs_y;
    logic [ADDR_W-1:0] r_clr, w_cur_addr, w_bs_addr, w_wr_addr;
    logic [7:0]        w_wr_data;
    logic              r_err, r_ack;
    logic              w_disp, w_home, w_wr_pend, w_wr_go, w_done;

    // Display requests are ignored while reset is held so every output reads 0.
    assign w_disp   = i_disp_req && i_rst_n;
    assign w_push   = i_cmd_valid && !r_full;
    assign w_pop    = (r_state == S_IDLE) && (r_cnt != '0);
    assign w_cnt_nx = r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop) r_rp <= r_rp + PW'(1);
            r_cnt  <= w_cnt_nx;
            r_full <= w_cnt_nx == (PW+1)'(FIFO_DEPTH);
        end

    always_ff @(posedge i_clk)
        if (w_push) r_fifo[r_wp] <= {i_cmd_op, i_cmd_param};

    assign w_home     = (r_x == '0) && (r_y == '0);
    assign w_bs_x     = (r_x == '0) ? 6'(COLS - 1) : r_x - 6'd1;
    assign w_bs_y     = (r_x == '0) ? r_y - 5'd1 : r_y;
    assign w_cur_addr = ADDR_W'(r_y) * ADDR_W'(COLS) + ADDR_W'(r_x);
    assign w_bs_addr  = ADDR_W'(w_bs_y) * ADDR_W'(COLS) + ADDR_W'(w_bs_x);
    assign w_wr_go    = w_wr_pend && !w_disp;

    always_comb begin
        w_state_nx = r_state;
        w_wr_pend  = 1'b0;
        w_wr_addr  = '0;
        w_wr_data  = '0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: w_state_nx = (r_cnt != '0) ? S_EXEC : S_IDLE;
            S_EXEC: begin
                w_wr_pend  = (r_op == OP_PUT) || ((r_op == OP_BS) && !w_home);
                w_wr_addr  = (r_op == OP_PUT) ? w_cur_addr : w_bs_addr;
                w_wr_data  = (r_op == OP_PUT) ? r_param[7:0] : 8'h00;
                w_done     = !w_wr_pend || !w_disp;
                w_state_nx = !w_done ? S_EXEC : (r_op == OP_CLR) ? S_CLEAR : S_IDLE;
            end
            S_CLEAR: begin
                w_wr_pend  = 1'b1;
                w_wr_addr  = r_clr;
                w_done     = !w_disp && (r_clr == LAST);
                w_state_nx = w_done ? S_IDLE : S_CLEAR;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= S_IDLE;
        else r_state <= w_state_nx;

    // Cursor and clear counter move only on the edge that retires the command's write.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_op    <= '0;
            r_param <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_clr   <= '0;
            r_err   <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= w_disp;
            r_err <= 1'b0;
            if (w_pop) {r_op, r_param} <= r_fifo[r_rp];
            if (r_state == S_EXEC && w_done)
                case (r_op)
                    OP_HOME: begin
                        r_x <= '0;
                        r_y <= '0;
                    end
                    OP_PUT: begin
                        r_x <= (r_x == 6'(COLS - 1)) ? '0 : r_x + 6'd1;
                        r_y <= (r_x != 6'(COLS - 1)) ? r_y : (r_y == 5'(ROWS - 1)) ? '0 : r_y + 5'd1;
                    end
                    OP_BS: if (!w_home) begin
                        r_x <= w_bs_x;
                        r_y <= w_bs_y;
                    end
                    OP_ROW: if (r_param < 16'(ROWS)) r_y <= r_param[4:0]; else r_err <= 1'b1;
                    OP_COL: if (r_param < 16'(COLS)) r_x <= r_param[5:0]; else r_err <= 1'b1;
                    OP_CLR: r_clr <= '0;
                    OP_NL: begin
                        r_x <= '0;
                        r_y <= (r_y == 5'(ROWS - 1)) ? '0 : r_y + 5'd1;
                    end
                    default: r_err <= 1'b1;
                endcase
            if (r_state == S_CLEAR && w_wr_go) begin
                r_clr <= r_clr + ADDR_W'(1);
                if (r_clr == LAST) begin
                    r_x <= '0;
                    r_y <= '0;
                end
            end
        end

    assign o_cmd_ready = !r_full;
    assign o_busy      = (r_cnt != '0) || (r_state != S_IDLE);
    assign o_cmd_err   = r_err;
    assign o_cur_x     = r_x;
    assign o_cur_y     = r_y;
    assign o_disp_ack  = r_ack;
    assign o_disp_data = r_ack ? i_mem_rdata : 8'h00;
    assign o_mem_en    = w_disp || w_wr_pend;
    assign o_mem_we    = w_wr_go;
    assign o_mem_addr  = w_disp ? i_disp_addr : w_wr_go ? w_wr_addr : '0;
    assign o_mem_wdata = w_wr_go ? w_wr_data : 8'h00;
endmodule

// File: tb/tb_gpu_text_ctrl.sv
// tb_gpu_text_ctrl: vector table, hand-timed sequences and randomized commands
// checked against a cell-level screen/cursor model with a RAM model attached.
module tb_gpu_text_ctrl;
    localparam int COLS  = 40;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_op = 8'h00;
    logic [15:0] cmd_param = 16'h0000;
    logic        disp_req = 1'b0;
    logic [9:0]  disp_addr = 10'd0;
    logic        disp_ack;
    logic [7:0]  disp_data;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic [5:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy, cmd_err;

    always #5 clk = ~clk;

    gpu_text_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_op(cmd_op), .i_cmd_param(cmd_param), .i_disp_req(disp_req), .i_disp_addr(disp_addr),
        .o_disp_ack(disp_ack), .o_disp_data(disp_data), .o_mem_en(mem_en), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_cur_x(cur_x), .o_cur_y(cur_y), .o_busy(busy), .o_cmd_err(cmd_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single-port character RAM attached to the DUT
    logic [7:0] ram [1024] = '{default: 8'h00};
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Display request driver: 0 off, 1 held, 2 alternating, 3 random ~30%
    int disp_mode = 0;
    always @(posedge clk) begin
        #1;
        disp_req  = (disp_mode == 1) ? 1'b1 : (disp_mode == 2) ? !disp_req :
                    (disp_mode == 3) ? ($urandom_range(0, 99) < 30) : 1'b0;
        disp_addr = 10'($urandom_range(0, 1023));
    end

    // Observed write stream, error pulses and display-path checks
    int wr_a[$];
    int wr_d[$];
    int err_seen = 0;
    bit disp_chk = 0;
    logic prev_req = 1'b0;
    logic [9:0] prev_addr = 10'd0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                wr_a.push_back(int'(mem_addr));
                wr_d.push_back(int'(mem_wdata));
            end
            if (cmd_err) err_seen++;
            if (disp_chk) begin
                chk("disp_ack", disp_ack, prev_req);
                chk("disp_data", disp_data, prev_req ? ram[prev_addr] : 8'h00);
                if (disp_req) chk("disp_arb", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, disp_addr});
            end
        end
        prev_req  = disp_req;
        prev_addr = disp_addr;
    end

    // Reference model: linear cell index arithmetic over a screen array
    int mx = 0, my = 0, exp_err = 0;
    int exp_a[$];
    int exp_d[$];
    logic [7:0] screen [CELLS] = '{default: 8'h00};

    function automatic void model_wr(input int a, input int d);
        exp_a.push_back(a);
        exp_d.push_back(d);
        screen[a] = 8'(d);
    endfunction

    function automatic void model_cmd(input int op, input int p);
        int lin = my * COLS + mx;
        case (op)
            'hC0: begin mx = 0; my = 0; end
            'hC1: begin
                model_wr(lin, p & 255);
                lin = (lin + 1) % CELLS;
                mx = lin % COLS; my = lin / COLS;
            end
            'hC2: if (lin > 0) begin
                lin--;
                model_wr(lin, 0);
                mx = lin % COLS; my = lin / COLS;
            end
            'hC3: if (p < ROWS) my = p; else exp_err++;
            'hC4: if (p < COLS) mx = p; else exp_err++;
            'hC5: begin
                for (int i = 0; i < CELLS; i++) model_wr(i, 0);
                mx = 0; my = 0;
            end
            'hC6: begin mx = 0; my = (my + 1) % ROWS; end
            default: exp_err++;
        endcase
    endfunction

    function automatic void clear_queues();
        wr_a.delete(); wr_d.delete(); exp_a.delete(); exp_d.delete();
    endfunction

    function automatic void model_reset();
        mx = 0; my = 0; exp_err = 0; err_seen = 0;
        clear_queues();
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {cmd_ready, busy, mem_en, mem_we, disp_ack, cmd_err}, 6'b100000);
        chk({tag, "_bus"}, {mem_addr, mem_wdata, disp_data}, 0);
        chk({tag, "_cur"}, {cur_x, cur_y}, 0);
    endtask

    task automatic do_reset();
        disp_mode = 0; cmd_valid = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); chk_quiet("in_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk); chk_quiet("after_reset");
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] op, input logic [15:0] p);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_param = p;
        while (!cmd_ready && n < 5000) begin @(posedge clk); #1; n++; end
        chk("send_timeout", n >= 5000, 0);
        @(posedge clk); #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int cyc);
        cyc = 0;
        while (busy && cyc < budget) begin @(posedge clk); #1; cyc++; end
        chk("idle_timeout", cyc >= budget, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        int bad = 0;
        chk({tag, "_x"}, cur_x, mx);
        chk({tag, "_y"}, cur_y, my);
        chk({tag, "_err"}, err_seen, exp_err);
        chk({tag, "_nwr"}, wr_a.size(), exp_a.size());
        for (int i = 0; i < wr_a.size() && i < exp_a.size(); i++)
            if (wr_a[i] != exp_a[i] || wr_d[i] != exp_d[i]) bad++;
        chk({tag, "_wrdata"}, bad, 0);
        clear_queues();
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [15:0] p;
        int x, y, err, nwr, addr, data;
    } vec_t;
    vec_t tbl[18];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, cyc, n, bad, e0, sel;
        bit r;
        logic [7:0] op;
        logic [15:0] p;
        tbl[0]  = '{8'hC1, 16'h0041, 1, 0, 0, 1, 0, 'h41};
        tbl[1]  = '{8'hC3, 16'd24, 1, 24, 0, 0, 0, 0};
        tbl[2]  = '{8'hC4, 16'd39, 39, 24, 0, 0, 0, 0};
        tbl[3]  = '{8'hC1, 16'h005A, 0, 0, 0, 1, 999, 'h5A};
        tbl[4]  = '{8'hC3, 16'd25, 0, 0, 1, 0, 0, 0};
        tbl[5]  = '{8'hC2, 16'd0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{8'hC4, 16'd0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{8'hC3, 16'd3, 0, 3, 0, 0, 0, 0};
        tbl[8]  = '{8'hC2, 16'd0, 39, 2, 0, 1, 119, 0};
        tbl[9]  = '{8'hC4, 16'd40, 39, 2, 1, 0, 0, 0};
        tbl[10] = '{8'hC6, 16'd0, 0, 3, 0, 0, 0, 0};
        tbl[11] = '{8'hC7, 16'd0, 0, 3, 1, 0, 0, 0};
        tbl[12] = '{8'hC3, 16'd24, 0, 24, 0, 0, 0, 0};
        tbl[13] = '{8'hC6, 16'd0, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{8'hC1, 16'h01FF, 1, 0, 0, 1, 0, 'hFF};
        tbl[15] = '{8'hC0, 16'd0, 0, 0, 0, 0, 0, 0};
        tbl[16] = '{8'hC4, 16'h0100, 0, 0, 1, 0, 0, 0};
        tbl[17] = '{8'hBF, 16'd0, 0, 0, 1, 0, 0, 0};

        do_reset();
        disp_chk = 1;

        // Put latency: accept at N, write during N+1, cursor new after N+2
        cmd_valid = 1'b1; cmd_op = 8'hC1; cmd_param = 16'h0041;
        chk("lat_ready", cmd_ready, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        model_cmd('hC1, 'h41);
        @(negedge clk); chk("lat_n_busy", busy, 1); chk("lat_n_we", mem_we, 0);
        @(negedge clk); chk("lat_n1_we", mem_we, 1); chk("lat_n1_addr", mem_addr, 0);
        chk("lat_n1_data", mem_wdata, 'h41); chk("lat_n1_x", cur_x, 0);
        @(negedge clk); chk("lat_n2_x", cur_x, 1); chk("lat_n2_busy", busy, 0); chk("lat_n2_we", mem_we, 0);
        @(posedge clk); #1;
        check_model("lat");

        // cmd_err pulses exactly during cycle N+2
        cmd_valid = 1'b1; cmd_op = 8'hC3; cmd_param = 16'd25;
        @(posedge clk); #1 cmd_valid = 1'b0;
        model_cmd('hC3, 25);
        @(negedge clk); chk("err_n", cmd_err, 0);
        @(negedge clk); chk("err_n1", cmd_err, 0);
        @(negedge clk); chk("err_n2", cmd_err, 1);
        @(negedge clk); chk("err_n3", cmd_err, 0); chk("err_y", cur_y, 0);
        @(posedge clk); #1;
        check_model("errt");

        do_reset();
        for (int i = 0; i < 18; i++) begin
            e0 = err_seen;
            model_cmd(int'(tbl[i].op), int'(tbl[i].p));
            send(tbl[i].op, tbl[i].p);
            wait_idle(100, cyc);
            chk($sformatf("tbl%0d_x", i), cur_x, tbl[i].x);
            chk($sformatf("tbl%0d_y", i), cur_y, tbl[i].y);
            chk($sformatf("tbl%0d_err", i), err_seen - e0, tbl[i].err);
            chk($sformatf("tbl%0d_nwr", i), wr_a.size(), tbl[i].nwr);
            if (tbl[i].nwr == 1 && wr_a.size() == 1) begin
                chk($sformatf("tbl%0d_addr", i), wr_a[0], tbl[i].addr);
                chk($sformatf("tbl%0d_data", i), wr_d[0], tbl[i].data);
            end
            clear_queues();
        end

        // FIFO fill while display holds the RAM: one put stalls in EXEC, four queue
        disp_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        acc = 0; cmd_valid = 1'b1; cmd_op = 8'hC1;
        for (int i = 0; i < 10; i++) begin
            cmd_param = 16'(16'h61 + acc);
            r = cmd_ready;
            @(posedge clk); #1;
            if (r) begin model_cmd('hC1, 'h61 + acc); acc++; end
        end
        cmd_valid = 1'b0;
        chk("fifo_accepts", acc, 5);
        chk("fifo_ready_full", cmd_ready, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("fifo_busy_stalled", busy, 1);
        chk("fifo_no_writes", wr_a.size(), 0);
        disp_mode = 0;
        wait_idle(200, cyc);
        check_model("fifo");

        // Clear with display requests on alternate cycles
        disp_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        model_cmd('hC5, 0);
        send(8'hC5, 16'd0);
        wait_idle(5000, cyc);
        chk("clr_cycles_ok", cyc >= 1990 && cyc <= 2015, 1);
        chk("clr_busy", busy, 0);
        check_model("clear");
        disp_mode = 0;

        // Asynchronous abort in the middle of a clear
        repeat (2) @(posedge clk);
        #1;
        model_cmd('hC3, 7);
        send(8'hC3, 16'd7);
        wait_idle(100, cyc);
        check_model("pre_abort");
        send(8'hC5, 16'd0);
        n = 0;
        while (!(mem_we && mem_addr == 10'd500) && n < 3000) begin @(negedge clk); n++; end
        chk("abort_reach500", n >= 3000, 0);
        #1 rst_n = 1'b0;
        #1 chk_quiet("abort");
        model_reset();
        for (int i = 0; i < 500; i++) screen[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_writes", wr_a.size(), 0);
        chk("abort_idle", {busy, cmd_ready, cur_x, cur_y}, {1'b0, 1'b1, 11'd0});

        // Randomized batches with random display contention
        disp_mode = 3;
        for (int b = 0; b < 15; b++) begin
            for (int k = 0; k < 4; k++) begin
                sel = $urandom_range(0, 9);
                case (sel)
                    0, 1, 2: op = 8'hC1;
                    3, 4:    op = 8'hC2;
                    5:       op = 8'hC3;
                    6:       op = 8'hC4;
                    7:       op = 8'hC6;
                    8:       op = 8'hC0;
                    default: op = $urandom_range(0, 1) ? 8'($urandom_range(0, 'hBF)) : 8'($urandom_range('hC7, 'hFF));
                endcase
                p = (op == 8'hC3 || op == 8'hC4) ? 16'($urandom_range(0, 45)) : 16'($urandom());
                model_cmd(int'(op), int'(p));
                send(op, p);
            end
            wait_idle(2000, cyc);
            check_model($sformatf("rnd%0d", b));
        end
        disp_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        bad = 0;
        for (int i = 0; i < CELLS; i++) if (ram[i] !== screen[i]) bad++;
        chk("ram_vs_model", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
